uc_secuencial: RTL and testbench

Counter-based sequential control unit for the shift-and-add multiplier datapath (Q shift register, accumulator A). It replaces the fixed time-slot generator with an explicit FSM and an iteration counter, so operand width is a parameter. It adds a start/busy/Fin handshake and synchronous reset. It drives the same datapath strobes: CargaQ, DesplazaQ, ResetA, CargaA and Fin.

---
 rtl/uc_secuencial.sv | 105 ++++++++++
 tb/tb_uc_secuencial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uc_secuencial.sv
// Sequencing controller for a shift-and-add multiplier datapath.
// An explicit FSM plus an iteration counter makes the operand width a parameter.
module uc_secuencial #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q0,
  output logic CargaQ,
  output logic ResetA,
  output logic CargaA,
  output logic DesplazaQ,
  output logic busy,
  output logic Fin
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAdd,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // start is only looked at in StIdle and StDone, so it is ignored while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StAdd;
      end
      StAdd: begin
        state_d = StShift;
      end
      StShift: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StAdd;
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Every strobe but CargaA is a pure state decode; CargaA is gated by q0 in StAdd only.
  always_comb begin
    CargaQ    = 1'b0;
    ResetA    = 1'b0;
    CargaA    = 1'b0;
    DesplazaQ = 1'b0;
    busy      = 1'b0;
    Fin       = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        CargaQ = 1'b1;
        ResetA = 1'b1;
        busy   = 1'b1;
      end
      StAdd: begin
        CargaA = q0;
        busy   = 1'b1;
      end
      StShift: begin
        DesplazaQ = 1'b1;
        busy      = 1'b1;
      end
      StDone: begin
        Fin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_secuencial.sv
// Scoreboard bench for uc_secuencial: expected strobe vectors are queued as stimulus is
// driven and popped on the falling edge. Vector order {CargaQ,ResetA,CargaA,DesplazaQ,busy,Fin}.
module tb_uc_secuencial;

  logic clk = 1'b0;
  logic rst_n;
  logic start4, q04, start2, q02;
  logic cq4, ra4, ca4, dq4, bs4, fn4;
  logic cq2, ra2, ca2, dq2, bs2, fn2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] exp;
    string      nm;
    bit         sel2;
    int         cyc;
  } sb_t;

  sb_t sb_q[$];

  always #5 clk = ~clk;

  uc_secuencial #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .q0(q04),
    .CargaQ(cq4), .ResetA(ra4), .CargaA(ca4), .DesplazaQ(dq4), .busy(bs4), .Fin(fn4)
  );

  uc_secuencial #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .q0(q02),
    .CargaQ(cq2), .ResetA(ra2), .CargaA(ca2), .DesplazaQ(dq2), .busy(bs2), .Fin(fn2)
  );

  wire [5:0] vec4 = {cq4, ra4, ca4, dq4, bs4, fn4};
  wire [5:0] vec2 = {cq2, ra2, ca2, dq2, bs2, fn2};

  // Expected strobes from the published timing: cycle 0 idle, 1 load, even ADD, odd SHIFT.
  function automatic logic [5:0] expv(input int n, input int c, input logic q);
    if (c == 1) return 6'b110010;
    if (c >= 2 && c <= 2 * n && (c % 2) == 0) return {2'b00, q, 3'b010};
    if (c >= 3 && c <= 2 * n + 1) return 6'b000110;
    if (c == 2 * n + 2) return 6'b000001;
    return 6'b000000;
  endfunction

  // Starts a cycle: waits for the rising edge, drives inputs, queues the expectation.
  task automatic cyc(input bit sel2, input logic st, input logic q, input logic rn,
                     input logic [5:0] exp, input string nm, input int c);
    sb_t e;
    @(posedge clk);
    #1;
    rst_n = rn;
    if (sel2) begin
      start2 = st;
      q02    = q;
    end else begin
      start4 = st;
      q04    = q;
    end
    e.exp  = exp;
    e.nm   = nm;
    e.sel2 = sel2;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic test_reset;
    sb_t e;
    logic [5:0] got;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, (i < 3), (i < 3), (i >= 3) ? 1'b1 : 1'b0, 6'b0, "reset", i);
      @(negedge clk);
      e = sb_q.pop_front();
      got = vec4;
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", e.nm, e.cyc, got, e.exp);
      end
    end
    checks++;
    if (vec2 !== 6'b0) begin
      failures++;
      $display("FAIL reset_n2: got %b expected %b", vec2, 6'b0);
    end
  endtask

  task automatic test_nominal;
    sb_t e;
    logic [5:0] got;
    logic [3:0] pat = 4'b1101;  // q0 = 1,0,1,1 at successive ADD cycles
    logic q;
    for (int c = 0; c <= 11; c++) begin
      q = (c >= 2 && c <= 8 && (c % 2) == 0) ? pat[(c - 2) / 2] : 1'b1;
      cyc(1'b0, (c == 0), q, 1'b1, expv(4, c, q), "nominal", c);
      @(negedge clk);
      e = sb_q.pop_front();
      got = vec4;
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", e.nm, e.cyc, got, e.exp);
      end
    end
  endtask

  task automatic test_handshake;
    sb_t e;
    logic [5:0] got, ex;
    for (int c = 0; c <= 17; c++) begin
      ex = (c <= 10) ? expv(4, c, 1'b0) : (c <= 14) ? 6'b000001 : 6'b000000;
      cyc(1'b0, (c <= 13), 1'b0, 1'b1, ex, "handshake", c);
      @(negedge clk);
      e = sb_q.pop_front();
      got = vec4;
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", e.nm, e.cyc, got, e.exp);
      end
    end
  endtask

  task automatic test_ignored_start;
    sb_t e;
    logic [5:0] got;
    logic [3:0] pat = 4'b1101;
    logic q, st;
    for (int c = 0; c <= 11; c++) begin
      q  = (c >= 2 && c <= 8 && (c % 2) == 0) ? pat[(c - 2) / 2] : 1'b0;
      st = (c <= 3) || (c == 5);
      cyc(1'b0, st, q, 1'b1, expv(4, c, q), "ignored_start", c);
      @(negedge clk);
      e = sb_q.pop_front();
      got = vec4;
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", e.nm, e.cyc, got, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    sb_t e;
    logic [5:0] got, ex;
    int d;
    for (int c = 0; c <= 18; c++) begin
      // Reset sampled at end of cycle 5; a fresh start in cycle 7 restarts the timeline.
      d  = c - 7;
      ex = (c <= 5) ? expv(4, c, 1'b1) : (c == 6) ? 6'b0 : expv(4, d, 1'b1);
      cyc(1'b0, (c == 0) || (c == 7), 1'b1, (c != 5), ex, "reset_mid", c);
      @(negedge clk);
      e = sb_q.pop_front();
      got = vec4;
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", e.nm, e.cyc, got, e.exp);
      end
    end
  endtask

  task automatic test_n2;
    sb_t e;
    logic [5:0] got;
    for (int c = 0; c <= 7; c++) begin
      cyc(1'b1, (c == 0), 1'b1, 1'b1, expv(2, c, 1'b1), "n2", c);
      @(negedge clk);
      e = sb_q.pop_front();
      got = vec2;
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", e.nm, e.cyc, got, e.exp);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start4 = 1'b1;
    q04    = 1'b1;
    start2 = 1'b0;
    q02    = 1'b0;
    test_reset();
    test_nominal();
    test_handshake();
    test_ignored_start();
    test_reset_mid();
    test_n2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
